// File: rtl/lookup_engine_mt.sv
// lookup_engine_mt: two-stage multi-tenant ternary lookup with per-tenant defaults; LOOKUP_HIT_CNT_EN adds per-entry hit counters
module lookup_engine_mt #(
  parameter int STAGE      = 0,
  parameter int KEY_LEN    = 896,
  parameter int PHV_LEN    = 1579,
  parameter int ACTION_LEN = 25,
  parameter int DEPTH      = 16,
  parameter int TENANT_W   = 4,
  parameter int TENANT_LSB = 0,
  localparam int IW = $clog2(DEPTH),
  localparam int AW = (IW > TENANT_W) ? IW : TENANT_W,
  localparam int DW = 2*KEY_LEN + TENANT_W + 1
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [KEY_LEN-1:0]    extract_key,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic                  cond_flag,
  input  logic [PHV_LEN-1:0]    pkt_hdr_vec,
  output logic [ACTION_LEN-1:0] action,
  output logic                  action_hit,
  output logic                  action_valid,
  input  logic                  action_ready,
  output logic [PHV_LEN-1:0]    pkt_hdr_vec_out,
  input  logic                  ctrl_wr_en,
  input  logic [1:0]            ctrl_wr_sel,
  input  logic [AW-1:0]         ctrl_wr_addr,
  input  logic [DW-1:0]         ctrl_wr_data,
  input  logic [IW-1:0]         ctrl_rd_addr,
  output logic [31:0]           ctrl_rd_data
);
  localparam int NT = 1 << TENANT_W;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] NT_W = (AW+1)'(NT);
  logic                  ent_v   [DEPTH];
  logic [TENANT_W-1:0]   ent_t   [DEPTH];
  logic [KEY_LEN-1:0]    ent_m   [DEPTH];
  logic [KEY_LEN-1:0]    ent_k   [DEPTH];
  logic [ACTION_LEN-1:0] act_ram [DEPTH];
  logic [ACTION_LEN-1:0] dflt    [NT];
  logic [DEPTH-1:0]      hit;
  logic [TENANT_W-1:0]   ten;
  logic                  s1_v, s1_c, s1_any;
  logic [DEPTH-1:0]      s1_hit;
  logic [TENANT_W-1:0]   s1_t;
  logic [PHV_LEN-1:0]    s1_phv;
  logic [IW-1:0]         win;
  logic [IW-1:0]         waddr;
  logic [TENANT_W-1:0]   taddr;
  logic                  en, ent_we, act_we, dfl_we;
  logic                  unused_bits;
  assign ten    = pkt_hdr_vec[TENANT_LSB +: TENANT_W];
  assign en     = ~action_valid | action_ready;
  assign key_ready = en & aresetn;
  assign waddr  = ctrl_wr_addr[IW-1:0];
  assign taddr  = ctrl_wr_addr[TENANT_W-1:0];
  assign ent_we = ctrl_wr_en & (ctrl_wr_sel == 2'b00) & ({1'b0, ctrl_wr_addr} < DEPTH_W);
  assign act_we = ctrl_wr_en & (ctrl_wr_sel == 2'b01) & ({1'b0, ctrl_wr_addr} < DEPTH_W);
  assign dfl_we = ctrl_wr_en & (ctrl_wr_sel == 2'b10) & ({1'b0, ctrl_wr_addr} < NT_W);
  assign s1_any = s1_c & |s1_hit;
  // Ternary compare of the incoming key against every entry of the same tenant
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++)
      hit[i] = ent_v[i] & (ent_t[i] == ten) & ~|((extract_key ^ ent_k[i]) & ent_m[i]);
  end
  // Lowest-index hit wins
  always_comb begin
    win = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (s1_hit[i]) win = IW'(i);
  end
  // Control-plane table writes; entry key/mask need no reset since valid gates them
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_v[i]   <= 1'b0;
        act_ram[i] <= '0;
      end
      for (int i = 0; i < NT; i++) dflt[i] <= '0;
    end else begin
      if (ent_we) begin
        ent_v[waddr] <= ctrl_wr_data[DW-1];
        ent_t[waddr] <= ctrl_wr_data[2*KEY_LEN +: TENANT_W];
        ent_m[waddr] <= ctrl_wr_data[KEY_LEN +: KEY_LEN];
        ent_k[waddr] <= ctrl_wr_data[KEY_LEN-1:0];
      end
      if (act_we) act_ram[waddr] <= ctrl_wr_data[ACTION_LEN-1:0];
      if (dfl_we) dflt[taddr] <= ctrl_wr_data[ACTION_LEN-1:0];
    end
  end
  // Two-stage pipeline advancing together under the global enable
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      s1_v            <= 1'b0;
      s1_c            <= 1'b0;
      s1_hit          <= '0;
      s1_t            <= '0;
      s1_phv          <= '0;
      action_valid    <= 1'b0;
      action          <= '0;
      action_hit      <= 1'b0;
      pkt_hdr_vec_out <= '0;
    end else if (en) begin
      s1_v <= key_valid;
      if (key_valid) begin
        s1_hit <= hit;
        s1_t   <= ten;
        s1_c   <= cond_flag;
        s1_phv <= pkt_hdr_vec;
      end
      action_valid <= s1_v;
      if (s1_v) begin
        action          <= s1_any ? act_ram[win] : dflt[s1_t];
        action_hit      <= s1_any;
        pkt_hdr_vec_out <= s1_phv;
      end
    end
  end
`ifdef LOOKUP_HIT_CNT_EN
  logic [31:0] cnt [DEPTH];
  // Saturating per-entry hit counters; rewriting an entry restarts its count
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
      ctrl_rd_data <= '0;
    end else begin
      if (en & s1_v & s1_any & ~&cnt[win]) cnt[win] <= cnt[win] + 32'd1;
      if (ent_we) cnt[waddr] <= '0;
      ctrl_rd_data <= cnt[ctrl_rd_addr];
    end
  end
  assign unused_bits = STAGE[0];
`else
  assign ctrl_rd_data = '0;
  assign unused_bits  = ^{STAGE[0], ctrl_rd_addr};
`endif
endmodule

// File: tb/tb_lookup_engine_mt.sv
// tb_lookup_engine_mt: directed vectors checked against a table-level model of lookup_engine_mt
module tb_lookup_engine_mt;
  localparam int KL = 16, PL = 48, AL = 25, D = 16, TW = 4, TL = 8, IW = 4, AW = 4, DW = 37;
`ifdef LOOKUP_HIT_CNT_EN
  localparam int EXP_CNT = 3;
`else
  localparam int EXP_CNT = 0;
`endif
  logic axis_clk = 0, aresetn = 0;
  logic [KL-1:0] extract_key = '0;
  logic key_valid = 0, key_ready, cond_flag = 0;
  logic [PL-1:0] pkt_hdr_vec = '0, pkt_hdr_vec_out;
  logic [AL-1:0] action;
  logic action_hit, action_valid, action_ready = 1;
  logic ctrl_wr_en = 0;
  logic [1:0] ctrl_wr_sel = '0;
  logic [AW-1:0] ctrl_wr_addr = '0;
  logic [DW-1:0] ctrl_wr_data = '0;
  logic [IW-1:0] ctrl_rd_addr = '0;
  logic [31:0] ctrl_rd_data;
  always #5 axis_clk = ~axis_clk;
  lookup_engine_mt #(.STAGE(0), .KEY_LEN(KL), .PHV_LEN(PL), .ACTION_LEN(AL), .DEPTH(D),
                     .TENANT_W(TW), .TENANT_LSB(TL)) dut (
    .axis_clk(axis_clk), .aresetn(aresetn), .extract_key(extract_key), .key_valid(key_valid),
    .key_ready(key_ready), .cond_flag(cond_flag), .pkt_hdr_vec(pkt_hdr_vec), .action(action),
    .action_hit(action_hit), .action_valid(action_valid), .action_ready(action_ready),
    .pkt_hdr_vec_out(pkt_hdr_vec_out), .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_sel(ctrl_wr_sel),
    .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data), .ctrl_rd_addr(ctrl_rd_addr),
    .ctrl_rd_data(ctrl_rd_data));
  int checks = 0, passed = 0, delivered = 0, seq = 0;
  logic          mv [D];
  logic [TW-1:0] mt [D];
  logic [KL-1:0] mm [D], mk [D];
  logic [AL-1:0] ma [D], md [16];
  typedef struct packed { logic [AL-1:0] a; logic h; logic [PL-1:0] p; } res_t;
  res_t q[$];
  res_t pv;
  logic pstall = 0;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  function automatic res_t model(input logic [KL-1:0] k, input logic [PL-1:0] p, input logic c);
    res_t r;
    logic [TW-1:0] t;
    t = p[TL +: TW];
    r.p = p;
    r.h = 1'b0;
    r.a = md[t];
    if (c)
      for (int i = 0; i < D; i++)
        if (mv[i] && mt[i] == t && ((k ^ mk[i]) & mm[i]) == '0) begin
          r.h = 1'b1;
          r.a = ma[i];
          break;
        end
    return r;
  endfunction
  initial begin
    for (int i = 0; i < D; i++) begin mv[i] = 0; mt[i] = '0; mm[i] = '0; mk[i] = '0; ma[i] = '0; end
    for (int i = 0; i < 16; i++) md[i] = '0;
  end
  always @(negedge axis_clk) begin
    chk("key_ready", key_ready, aresetn & (!action_valid | action_ready));
    if (!aresetn) begin
      q.delete();
      pstall = 0;
      for (int i = 0; i < D; i++) begin mv[i] = 0; ma[i] = '0; end
      for (int i = 0; i < 16; i++) md[i] = '0;
    end else begin
      if (pstall) begin
        chk("hold_action", action, pv.a);
        chk("hold_hit", action_hit, pv.h);
        chk("hold_phv", pkt_hdr_vec_out, pv.p);
        chk("hold_valid", action_valid, 1);
      end
      if (action_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL spurious_valid: action_valid=1 with nothing expected");
        end else begin
          chk("action", action, q[0].a);
          chk("hit", action_hit, q[0].h);
          chk("phv", pkt_hdr_vec_out, q[0].p);
          if (action_ready) begin void'(q.pop_front()); delivered++; end
        end
      end
      pstall = action_valid & !action_ready;
      pv = {action, action_hit, pkt_hdr_vec_out};
      if (key_valid && key_ready) q.push_back(model(extract_key, pkt_hdr_vec, cond_flag));
      if (ctrl_wr_en)
        case (ctrl_wr_sel)
          2'b00: begin
            mv[ctrl_wr_addr] = ctrl_wr_data[36];
            mt[ctrl_wr_addr] = ctrl_wr_data[35:32];
            mm[ctrl_wr_addr] = ctrl_wr_data[31:16];
            mk[ctrl_wr_addr] = ctrl_wr_data[15:0];
          end
          2'b01: ma[ctrl_wr_addr] = ctrl_wr_data[AL-1:0];
          2'b10: md[ctrl_wr_addr] = ctrl_wr_data[AL-1:0];
          default: ;
        endcase
    end
  end
  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask
  task automatic wr(input logic [1:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ctrl_wr_en = 1; ctrl_wr_sel = sel; ctrl_wr_addr = a; ctrl_wr_data = d;
    tick();
    ctrl_wr_en = 0;
  endtask
  task automatic ent(input logic [AW-1:0] a, input logic v, input logic [TW-1:0] t,
                     input logic [KL-1:0] m, input logic [KL-1:0] k);
    wr(2'b00, a, {v, t, m, k});
  endtask
  function automatic logic [PL-1:0] mkphv(input int s, input logic [TW-1:0] t);
    return {16'(s), 20'hC0FFE, t, 8'h5A};
  endfunction
  task automatic one(input logic [KL-1:0] k, input logic [TW-1:0] t, input logic c,
                     input logic [AL-1:0] ea, input logic eh, input string n);
    logic [PL-1:0] p;
    p = mkphv(seq, t);
    seq++;
    extract_key = k; pkt_hdr_vec = p; cond_flag = c; key_valid = 1;
    tick();
    key_valid = 0;
    chk({n, "_lat1_valid"}, action_valid, 0);
    tick();
    chk({n, "_valid"}, action_valid, 1);
    chk({n, "_action"}, action, ea);
    chk({n, "_hit"}, action_hit, eh);
    chk({n, "_phv"}, pkt_hdr_vec_out, p);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [KL-1:0] ks [4];
    logic [TW-1:0] ts [4];
    int sent, d0;
    repeat (2) tick();
    chk("rst_key_ready", key_ready, 0);
    chk("rst_valid", action_valid, 0);
    aresetn = 1;
    tick();
    chk("post_rst_key_ready", key_ready, 1);
    chk("post_rst_valid", action_valid, 0);
    chk("post_rst_rd_data", ctrl_rd_data, 0);
    wr(2'b10, 2, DW'(25'h022));
    wr(2'b10, 5, DW'(25'h1FF));
    ent(3, 1, 2, 16'hFFFF, 16'h00AB);
    wr(2'b01, 3, DW'(25'h0A5));
    one(16'h00AB, 2, 1, 25'h0A5, 1, "s1_hit");
    ent(1, 1, 2, 16'hFFF0, 16'h00A0);
    wr(2'b01, 1, DW'(25'h111));
    one(16'h00AB, 2, 1, 25'h111, 1, "s2_prio");
    ent(1, 0, 2, 16'hFFF0, 16'h00A0);
    one(16'h00AB, 2, 1, 25'h0A5, 1, "s2_inval");
    one(16'h00AB, 5, 1, 25'h1FF, 0, "s3_tenant_miss");
    one(16'h00AB, 2, 0, 25'h022, 0, "s3_bypass");
    ent(7, 1, 5, 16'h0000, 16'h0000);
    wr(2'b01, 7, DW'(25'h777));
    wr(2'b11, 7, DW'(25'h0DEAD));
    one(16'h1234, 5, 1, 25'h777, 1, "zero_mask");
    one(16'h1234, 6, 1, 25'h000, 0, "other_tenant");
    ent(7, 0, 5, 16'h0000, 16'h0000);
    ks = '{16'h00AB, 16'h0000, 16'h00AB, 16'h00AB};
    ts = '{4'd2, 4'd2, 4'd5, 4'd2};
    sent = 0;
    d0 = delivered;
    for (int c = 0; c < 14; c++) begin
      action_ready = !(c >= 3 && c <= 5);
      key_valid = sent < 4;
      if (sent < 4) begin
        extract_key = ks[sent];
        pkt_hdr_vec = mkphv(100 + sent, ts[sent]);
        cond_flag = 1;
      end
      #1;
      if (c == 4) chk("s4_stall_key_ready", key_ready, 0);
      if (key_valid && key_ready) sent++;
      @(posedge axis_clk);
      #2;
    end
    key_valid = 0;
    action_ready = 1;
    chk("s4_sent", sent, 4);
    chk("s4_delivered", delivered - d0, 4);
    extract_key = 16'h00AB; pkt_hdr_vec = mkphv(200, 2); cond_flag = 1; key_valid = 1;
    ctrl_wr_en = 1; ctrl_wr_sel = 2'b00; ctrl_wr_addr = 3; ctrl_wr_data = {1'b0, 4'd2, 16'hFFFF, 16'h00AB};
    tick();
    key_valid = 0; ctrl_wr_en = 0;
    tick();
    chk("s5_old_valid", action_valid, 1);
    chk("s5_old_action", action, 25'h0A5);
    chk("s5_old_hit", action_hit, 1);
    one(16'h00AB, 2, 1, 25'h022, 0, "s5_after");
    ent(3, 1, 2, 16'hFFFF, 16'h00AB);
    for (int i = 0; i < 3; i++) one(16'h00AB, 2, 1, 25'h0A5, 1, "s6_cnt");
    ctrl_rd_addr = 3;
    tick();
    tick();
    chk("s6_counter", ctrl_rd_data, EXP_CNT);
    extract_key = 16'h00AB; pkt_hdr_vec = mkphv(300, 2); cond_flag = 1; key_valid = 1;
    tick();
    aresetn = 0;
    #1;
    chk("s6_rst_key_ready", key_ready, 0);
    tick();
    chk("s6_rst_valid", action_valid, 0);
    key_valid = 0;
    aresetn = 1;
    tick();
    chk("s6_drop_valid", action_valid, 0);
    tick();
    chk("s6_rst_counter", ctrl_rd_data, 0);
    one(16'h00AB, 2, 1, 25'h000, 0, "s6_post_rst_miss");
    tick();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
